// File: rtl/avl_cpu_bridge.sv
// Narrow CPU port to wide Avalon-MM bridge, one transaction in flight; optional LINE_CACHE_EN read line buffer.
// Latency req->ready: write 2, read 3 (immediate data), be==0 write / buffer hit 2; timeout after TIMEOUT busy cycles.
// Backpressure: command held while avl_wait is high; cpu_req is only sampled in IDLE.
module avl_cpu_bridge #(
  parameter int ADDR_W     = 26,
  parameter int AVL_W      = 128,
  parameter int CPU_W      = 32,
  parameter int CPU_ADDR_W = 32,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  iCLK,
  input  logic                  iRST_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [CPU_ADDR_W-1:0] cpu_addr,
  input  logic [CPU_W/8-1:0]    cpu_be,
  input  logic [CPU_W-1:0]      cpu_wdata,
  output logic [CPU_W-1:0]      cpu_rdata,
  output logic                  cpu_ready,
  output logic                  cpu_err,
  output logic [ADDR_W-1:0]     avl_address,
  output logic                  avl_read,
  output logic                  avl_write,
  output logic [AVL_W-1:0]      avl_writedata,
  output logic [AVL_W/8-1:0]    avl_byteenable,
  input  logic                  avl_wait,
  input  logic [AVL_W-1:0]      avl_readdata,
  input  logic                  avl_readdatavalid
);

  localparam int BPC = CPU_W / 8;
  localparam int NL  = AVL_W / CPU_W;
  localparam int LW  = (NL > 1) ? $clog2(NL) : 1;
  localparam int LSB = $clog2(AVL_W / 8);
  localparam int CB  = $clog2(BPC);
  localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, WR_CMD, RD_CMD, RD_WAIT, DONE} state_t;

  state_t            state;
  logic [TW-1:0]     tmo_cnt;
  logic [LW-1:0]     lane_q;
  logic              stale;

  logic [LW-1:0]     req_lane;
  logic [ADDR_W-1:0] req_word;
  logic [AVL_W/8-1:0] req_be;
  logic [AVL_W-1:0]  req_wdat;
  logic              beat;
  logic              tmo_hit;
  logic              busy;
  logic              acc;
  logic              fill;
  logic              line_hit;
  logic [AVL_W-1:0]  hit_dat;
  logic              unused_addr;

  function automatic logic [CPU_W-1:0] lane_pick(input logic [AVL_W-1:0] d, input logic [LW-1:0] l);
    lane_pick = '0;
    for (int i = 0; i < NL; i++)
      if (l == LW'(i)) lane_pick = d[i*CPU_W +: CPU_W];
  endfunction

  assign req_lane    = (NL > 1) ? cpu_addr[CB +: LW] : '0;
  assign req_word    = cpu_addr[LSB +: ADDR_W];
  assign req_wdat    = {NL{cpu_wdata}};
  assign unused_addr = ^cpu_addr;

  always_comb begin
    req_be = '0;
    for (int i = 0; i < NL; i++)
      if (req_lane == LW'(i)) req_be[i*BPC +: BPC] = cpu_be;
  end

  // A beat arriving while stale belongs to a timed-out read and is dropped.
  assign beat    = avl_readdatavalid & ~stale;
  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_MAX);
  assign busy    = (state == WR_CMD) || (state == RD_CMD) || (state == RD_WAIT);
  assign acc     = (state == IDLE) && cpu_req;
  assign fill    = beat && !tmo_hit && (((state == RD_CMD) && !avl_wait) || (state == RD_WAIT));

`ifdef LINE_CACHE_EN
  logic              line_vld;
  logic [ADDR_W-1:0] line_tag;
  logic [AVL_W-1:0]  line_dat;
  logic [AVL_W-1:0]  line_mrg;

  assign line_hit = line_vld && (line_tag == req_word);
  assign hit_dat  = line_dat;

  always_comb begin
    line_mrg = line_dat;
    for (int b = 0; b < AVL_W/8; b++)
      if (req_be[b]) line_mrg[b*8 +: 8] = req_wdat[b*8 +: 8];
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      line_vld <= 1'b0;
      line_tag <= '0;
      line_dat <= '0;
    end else if (busy && tmo_hit) begin
      line_vld <= 1'b0;
    end else if (fill) begin
      line_vld <= 1'b1;
      line_tag <= avl_address;
      line_dat <= avl_readdata;
    end else if (acc && cpu_we && line_hit) begin
      line_dat <= line_mrg;
    end
  end
`else
  assign line_hit = 1'b0;
  assign hit_dat  = '0;
`endif

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state          <= IDLE;
      tmo_cnt        <= '0;
      lane_q         <= '0;
      stale          <= 1'b0;
      cpu_rdata      <= '0;
      cpu_ready      <= 1'b0;
      cpu_err        <= 1'b0;
      avl_address    <= '0;
      avl_read       <= 1'b0;
      avl_write      <= 1'b0;
      avl_writedata  <= '0;
      avl_byteenable <= '0;
    end else begin
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      if (avl_readdatavalid && stale) stale <= 1'b0;

      if (busy && tmo_hit) begin
        avl_read  <= 1'b0;
        avl_write <= 1'b0;
        cpu_rdata <= '0;
        cpu_ready <= 1'b1;
        cpu_err   <= 1'b1;
        state     <= IDLE;
        // Command was taken in RD_WAIT, so a beat is still owed unless it lands now.
        if (state == RD_WAIT) stale <= ~beat;
      end else begin
        if (busy) tmo_cnt <= tmo_cnt + 1'b1;
        case (state)
          IDLE: if (cpu_req) begin
            tmo_cnt       <= '0;
            lane_q        <= req_lane;
            avl_address   <= req_word;
            avl_writedata <= req_wdat;
            if (cpu_we) begin
              avl_byteenable <= req_be;
              if (|cpu_be) begin
                avl_write <= 1'b1;
                state     <= WR_CMD;
              end else begin
                state <= DONE;
              end
            end else if (line_hit) begin
              cpu_rdata <= lane_pick(hit_dat, req_lane);
              state     <= DONE;
            end else begin
              avl_byteenable <= '1;
              avl_read       <= 1'b1;
              state          <= RD_CMD;
            end
          end
          WR_CMD: if (!avl_wait) begin
            avl_write <= 1'b0;
            cpu_ready <= 1'b1;
            state     <= DONE;
          end
          RD_CMD: if (!avl_wait) begin
            avl_read <= 1'b0;
            if (beat) begin
              cpu_rdata <= lane_pick(avl_readdata, lane_q);
              cpu_ready <= 1'b1;
              state     <= DONE;
            end else begin
              state <= RD_WAIT;
            end
          end
          RD_WAIT: if (beat) begin
            cpu_rdata <= lane_pick(avl_readdata, lane_q);
            cpu_ready <= 1'b1;
            state     <= DONE;
          end
          // Paths that skip Avalon arrive with ready low and spend one cycle raising it.
          DONE: begin
            if (!cpu_ready) cpu_ready <= 1'b1;
            else            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
